// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcodes, flag bit positions and shift FSM states shared by the
//           ALU/register-file pipeline block.
// Revision: 1.0 - initial parametrised release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_LSH  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_ADDC = 4'b0111;
    localparam logic [3:0] OP_RSH  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_ARSH = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_MOV  = 4'b1101;

    // Bit positions inside the five-bit {C, L, F, Z, N} flags register
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_n.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_n
// Brief   : NUM_REGS x WIDTH register file, one synchronous write port,
//           two combinational operand read ports and a combinational debug
//           read port; asynchronous active-low clear.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module reg_file_n #(
    parameter  int WIDTH    = 16,
    parameter  int NUM_REGS = 16,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [RW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [RW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [RW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem [NUM_REGS];

    // Storage: cleared asynchronously, at most one register written per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_sel];

endmodule
`default_nettype wire

// File: rtl/alu_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module  : alu_reg_pipe
// Brief   : ALU + register file + flags with a valid/ready instruction port,
//           an iterative one-bit-per-cycle shifter and a write-back strobe.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module alu_reg_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int NUM_REGS = 16,
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [RW-1:0]    rdest,
    input  logic [RW-1:0]    rsrc,
    input  logic             reg_or_imm,
    input  logic [WIDTH-1:0] immediate,
    output logic [4:0]       flags,
    output logic             out_valid,
    output logic [RW-1:0]    wb_addr,
    output logic [WIDTH-1:0] wb_data,
    input  logic [RW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int SW = $clog2(WIDTH);

    shift_state_t     state, state_nx;
    logic [4:0]       flags_nx;
    logic [WIDTH-1:0] sh_reg, sh_reg_nx;
    logic [SW-1:0]    sh_cnt, sh_cnt_nx;
    logic [3:0]       sh_op, sh_op_nx;
    logic [RW-1:0]    sh_dest, sh_dest_nx;

    logic             we;
    logic [RW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] opnd_a, rd_b, opnd_b;
    logic [SW-1:0]    amount;
    logic             accept;
    logic             carry_in;
    logic [WIDTH:0]   add_full, sub_full;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] sh_step;

    // One step of the iterative shifter; RSH and anything else fill with zero
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input logic [3:0]       kind);
        logic [WIDTH-1:0] r;
        case (kind)
            OP_LSH:  r = {v[WIDTH-2:0], 1'b0};
            OP_ARSH: r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {1'b0, v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    reg_file_n #(
        .WIDTH   (WIDTH),
        .NUM_REGS(NUM_REGS)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (rdest),
        .rdata_a (opnd_a),
        .raddr_b (rsrc),
        .rdata_b (rd_b),
        .dbg_sel (dbg_sel),
        .dbg_data(dbg_data)
    );

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign opnd_b   = reg_or_imm ? rd_b : immediate;
    assign amount   = opnd_b[SW-1:0];
    assign carry_in = (op == OP_ADDC) & flags[FLAG_C];

    // The extra top bit of add_full is carry out; of sub_full it is the borrow (A<B unsigned)
    assign add_full = {1'b0, opnd_a} + {1'b0, opnd_b} + {{WIDTH{1'b0}}, carry_in};
    assign sub_full = {1'b0, opnd_a} - {1'b0, opnd_b};
    assign add_ovf  = (opnd_a[WIDTH-1] == opnd_b[WIDTH-1]) && (add_full[WIDTH-1] != opnd_a[WIDTH-1]);
    assign sub_ovf  = (opnd_a[WIDTH-1] != opnd_b[WIDTH-1]) && (sub_full[WIDTH-1] != opnd_a[WIDTH-1]);
    assign sh_step  = shift_one(sh_reg, sh_op);

    // Next state, register write request and flag updates
    always_comb begin
        state_nx   = state;
        flags_nx   = flags;
        we         = 1'b0;
        waddr      = rdest;
        wdata      = '0;
        sh_reg_nx  = sh_reg;
        sh_cnt_nx  = sh_cnt;
        sh_op_nx   = sh_op;
        sh_dest_nx = sh_dest;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_AND, OP_OR, OP_XOR, OP_MOV: begin
                            we = 1'b1;
                            case (op)
                                OP_AND:  wdata = opnd_a & opnd_b;
                                OP_OR:   wdata = opnd_a | opnd_b;
                                OP_XOR:  wdata = opnd_a ^ opnd_b;
                                default: wdata = opnd_b;
                            endcase
                            flags_nx[FLAG_Z] = (wdata == '0);
                        end
                        OP_ADD, OP_ADDC: begin
                            we               = 1'b1;
                            wdata            = add_full[WIDTH-1:0];
                            flags_nx[FLAG_C] = add_full[WIDTH];
                            flags_nx[FLAG_F] = add_ovf;
                            flags_nx[FLAG_Z] = (add_full[WIDTH-1:0] == '0);
                        end
                        OP_ADDU: begin
                            we               = 1'b1;
                            wdata            = add_full[WIDTH-1:0];
                            flags_nx[FLAG_C] = add_full[WIDTH];
                        end
                        OP_SUB: begin
                            we               = 1'b1;
                            wdata            = sub_full[WIDTH-1:0];
                            flags_nx[FLAG_C] = sub_full[WIDTH];
                            flags_nx[FLAG_F] = sub_ovf;
                            flags_nx[FLAG_Z] = (sub_full[WIDTH-1:0] == '0);
                        end
                        OP_CMP: begin
                            flags_nx[FLAG_C] = sub_full[WIDTH];
                            flags_nx[FLAG_L] = sub_full[WIDTH];
                            flags_nx[FLAG_F] = sub_ovf;
                            flags_nx[FLAG_Z] = (opnd_a == opnd_b);
                            flags_nx[FLAG_N] = ($signed(opnd_a) < $signed(opnd_b));
                        end
                        OP_LSH, OP_RSH, OP_ARSH: begin
                            if (amount == '0) begin
                                // Zero-length shift completes immediately as a rewrite
                                we               = 1'b1;
                                wdata            = opnd_a;
                                flags_nx[FLAG_Z] = (opnd_a == '0);
                            end else begin
                                state_nx   = ST_SHIFT;
                                sh_reg_nx  = opnd_a;
                                sh_cnt_nx  = amount;
                                sh_op_nx   = op;
                                sh_dest_nx = rdest;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                sh_reg_nx = sh_step;
                sh_cnt_nx = sh_cnt - 1'b1;
                if (sh_cnt == SW'(1)) begin
                    state_nx         = ST_IDLE;
                    we               = 1'b1;
                    waddr            = sh_dest;
                    wdata            = sh_step;
                    flags_nx[FLAG_Z] = (sh_step == '0);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, flags, shifter context and write-back strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flags     <= '0;
            sh_reg    <= '0;
            sh_cnt    <= '0;
            sh_op     <= OP_NOP;
            sh_dest   <= '0;
            out_valid <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            state     <= state_nx;
            flags     <= flags_nx;
            sh_reg    <= sh_reg_nx;
            sh_cnt    <= sh_cnt_nx;
            sh_op     <= sh_op_nx;
            sh_dest   <= sh_dest_nx;
            out_valid <= we;
            if (we) begin
                wb_addr <= waddr;
                wb_data <= wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_reg_pipe
// Brief   : Directed self-checking bench for alu_reg_pipe; a 16-bit/16-reg
//           instance and an 8-bit/8-reg instance share clock and reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_reg_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 16-bit instance signals
    logic        a_in_valid, a_in_ready, a_reg_or_imm, a_out_valid;
    logic [3:0]  a_op, a_rdest, a_rsrc, a_wb_addr, a_dbg_sel;
    logic [15:0] a_imm, a_wb_data, a_dbg_data;
    logic [4:0]  a_flags;

    // 8-bit instance signals
    logic        b_in_valid, b_in_ready, b_reg_or_imm, b_out_valid;
    logic [3:0]  b_op;
    logic [2:0]  b_rdest, b_rsrc, b_wb_addr, b_dbg_sel;
    logic [7:0]  b_imm, b_wb_data, b_dbg_data;
    logic [4:0]  b_flags;

    int tests  = 0;
    int failed = 0;

    alu_reg_pipe #(.WIDTH(16), .NUM_REGS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op(a_op), .rdest(a_rdest), .rsrc(a_rsrc), .reg_or_imm(a_reg_or_imm),
        .immediate(a_imm), .flags(a_flags), .out_valid(a_out_valid),
        .wb_addr(a_wb_addr), .wb_data(a_wb_data), .dbg_sel(a_dbg_sel), .dbg_data(a_dbg_data)
    );

    alu_reg_pipe #(.WIDTH(8), .NUM_REGS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(b_op), .rdest(b_rdest), .rsrc(b_rsrc), .reg_or_imm(b_reg_or_imm),
        .immediate(b_imm), .flags(b_flags), .out_valid(b_out_valid),
        .wb_addr(b_wb_addr), .wb_data(b_wb_data), .dbg_sel(b_dbg_sel), .dbg_data(b_dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic issue16(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic roi, input logic [15:0] imm);
        @(negedge clk);
        a_in_valid = 1'b1; a_op = op; a_rdest = rd; a_rsrc = rs; a_reg_or_imm = roi; a_imm = imm;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic roi, input logic [7:0] imm);
        @(negedge clk);
        b_in_valid = 1'b1; b_op = op; b_rdest = rd; b_rsrc = rs; b_reg_or_imm = roi; b_imm = imm;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic wb16(input string tag, input logic [3:0] addr, input logic [15:0] data,
                        input logic [4:0] fl);
        chk({tag, ".valid"}, a_out_valid, 1);
        chk({tag, ".addr"},  a_wb_addr,   addr);
        chk({tag, ".data"},  a_wb_data,   data);
        chk({tag, ".flags"}, a_flags,     fl);
        a_dbg_sel = addr;
        #1;
        chk({tag, ".dbg"},   a_dbg_data,  data);
    endtask

    task automatic wb8(input string tag, input logic [2:0] addr, input logic [7:0] data,
                       input logic [4:0] fl);
        chk({tag, ".valid"}, b_out_valid, 1);
        chk({tag, ".addr"},  b_wb_addr,   addr);
        chk({tag, ".data"},  b_wb_data,   data);
        chk({tag, ".flags"}, b_flags,     fl);
        b_dbg_sel = addr;
        #1;
        chk({tag, ".dbg"},   b_dbg_data,  data);
    endtask

    // Called right after a shift is accepted; counts busy cycles with a budget
    task automatic shift_wait16(input string tag, input int cycles);
        int n = 0;
        chk({tag, ".busy"}, a_in_ready, 0);
        while (a_in_ready !== 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".cycles"}, n, cycles);
    endtask

    task automatic shift_wait8(input string tag, input int cycles);
        int n = 0;
        chk({tag, ".busy"}, b_in_ready, 0);
        while (b_in_ready !== 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".cycles"}, n, cycles);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_op = OP_NOP; a_rdest = '0; a_rsrc = '0; a_reg_or_imm = 1'b0;
        a_imm = '0; a_dbg_sel = 4'd15;
        b_in_valid = 1'b0; b_op = OP_NOP; b_rdest = '0; b_rsrc = '0; b_reg_or_imm = 1'b0;
        b_imm = '0; b_dbg_sel = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        chk("rst16.ready", a_in_ready, 1);
        chk("rst16.valid", a_out_valid, 0);
        chk("rst16.flags", a_flags, 5'h00);
        chk("rst16.r15",   a_dbg_data, 16'h0000);
        chk("rst8.ready",  b_in_ready, 1);
        chk("rst8.flags",  b_flags, 5'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel16.valid", a_out_valid, 0);
        chk("rel16.ready", a_in_ready, 1);

        // Arithmetic and logic sequence on R15
        issue16(OP_MOV, 4'd15, 4'd0, 1'b0, 16'h0003); wb16("mov3", 4'd15, 16'h0003, 5'h00);
        @(posedge clk); #1;
        chk("mov3.strobe_end", a_out_valid, 0);
        issue16(OP_AND, 4'd15, 4'd0, 1'b0, 16'h0001); wb16("and1",  4'd15, 16'h0001, 5'h00);
        issue16(OP_ADD, 4'd15, 4'd0, 1'b0, 16'h0009); wb16("add9",  4'd15, 16'h000A, 5'h00);
        issue16(OP_SUB, 4'd15, 4'd0, 1'b0, 16'h0014); wb16("sub20", 4'd15, 16'hFFF6, 5'h10);
        issue16(OP_CMP, 4'd15, 4'd0, 1'b0, 16'hFFFB);
        chk("cmp.valid", a_out_valid, 0);
        chk("cmp.flags", a_flags, 5'h19);
        a_dbg_sel = 4'd15; #1;
        chk("cmp.r15", a_dbg_data, 16'hFFF6);

        // Shifts
        issue16(OP_MOV,  4'd15, 4'd0, 1'b0, 16'h0001); wb16("mov1", 4'd15, 16'h0001, 5'h19);
        issue16(OP_LSH,  4'd15, 4'd0, 1'b0, 16'h000E); shift_wait16("lsh14", 14);
        wb16("lsh14", 4'd15, 16'h4000, 5'h19);
        issue16(OP_LSH,  4'd15, 4'd0, 1'b0, 16'h0002); shift_wait16("lsh2", 2);
        wb16("lsh2", 4'd15, 16'h0000, 5'h1B);
        issue16(OP_MOV,  4'd15, 4'd0, 1'b0, 16'h8000); wb16("mov8000", 4'd15, 16'h8000, 5'h19);
        issue16(OP_ARSH, 4'd15, 4'd0, 1'b0, 16'h0003); shift_wait16("arsh3", 3);
        wb16("arsh3", 4'd15, 16'hF000, 5'h19);
        issue16(OP_RSH,  4'd15, 4'd0, 1'b0, 16'h0010);
        chk("rsh0.ready", a_in_ready, 1);
        wb16("rsh0", 4'd15, 16'hF000, 5'h19);
        issue16(OP_RSH,  4'd15, 4'd0, 1'b0, 16'h0004); shift_wait16("rsh4", 4);
        wb16("rsh4", 4'd15, 16'h0F00, 5'h19);

        // Carry, wrap, carry-in, register operand, overflow, ADDU, logic, NOP
        issue16(OP_MOV,  4'd1, 4'd0, 1'b0, 16'hFFFF); wb16("movffff", 4'd1, 16'hFFFF, 5'h19);
        issue16(OP_ADD,  4'd1, 4'd0, 1'b0, 16'h0001); wb16("addwrap", 4'd1, 16'h0000, 5'h1B);
        issue16(OP_ADDC, 4'd0, 4'd0, 1'b0, 16'h0000); wb16("addc",    4'd0, 16'h0001, 5'h09);
        issue16(OP_MOV,  4'd2, 4'd0, 1'b0, 16'h0005); wb16("mov5",    4'd2, 16'h0005, 5'h09);
        issue16(OP_ADD,  4'd2, 4'd0, 1'b1, 16'hDEAD); wb16("addreg",  4'd2, 16'h0006, 5'h09);
        issue16(OP_MOV,  4'd3, 4'd0, 1'b0, 16'h7FFF); wb16("mov7fff", 4'd3, 16'h7FFF, 5'h09);
        issue16(OP_ADD,  4'd3, 4'd0, 1'b0, 16'h0001); wb16("addovf",  4'd3, 16'h8000, 5'h0D);
        issue16(OP_ADDU, 4'd3, 4'd3, 1'b1, 16'h0000); wb16("addu",    4'd3, 16'h0000, 5'h1D);
        issue16(OP_OR,   4'd3, 4'd0, 1'b0, 16'h00F0); wb16("or",      4'd3, 16'h00F0, 5'h1D);
        issue16(OP_XOR,  4'd3, 4'd0, 1'b0, 16'h00F0); wb16("xor",     4'd3, 16'h0000, 5'h1F);
        issue16(OP_NOP,  4'd3, 4'd0, 1'b0, 16'h0005);
        chk("nop.valid", a_out_valid, 0);
        chk("nop.flags", a_flags, 5'h1F);

        // Reset during a long shift discards it
        issue16(OP_LSH, 4'd2, 4'd0, 1'b0, 16'h000A);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst.busy", a_in_ready, 0);
        #2;
        rst_n = 1'b0;
        a_dbg_sel = 4'd2;
        #1;
        chk("midrst.ready", a_in_ready, 1);
        chk("midrst.valid", a_out_valid, 0);
        chk("midrst.flags", a_flags, 5'h00);
        chk("midrst.r2",    a_dbg_data, 16'h0000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (a_out_valid !== 1'b0) seen = 1'b1;
        end
        chk("midrst.no_wb", seen, 0);
        chk("midrst.idle",  a_in_ready, 1);
        chk("midrst.r2_after", a_dbg_data, 16'h0000);

        // Same arithmetic sequence on the 8-bit / 8-register instance, R7
        issue8(OP_MOV, 3'd7, 3'd0, 1'b0, 8'h03); wb8("b.mov3",  3'd7, 8'h03, 5'h00);
        issue8(OP_AND, 3'd7, 3'd0, 1'b0, 8'h01); wb8("b.and1",  3'd7, 8'h01, 5'h00);
        issue8(OP_ADD, 3'd7, 3'd0, 1'b0, 8'h09); wb8("b.add9",  3'd7, 8'h0A, 5'h00);
        issue8(OP_SUB, 3'd7, 3'd0, 1'b0, 8'h14); wb8("b.sub20", 3'd7, 8'hF6, 5'h10);
        issue8(OP_CMP, 3'd7, 3'd0, 1'b0, 8'hFB);
        chk("b.cmp.valid", b_out_valid, 0);
        chk("b.cmp.flags", b_flags, 5'h19);
        issue8(OP_MOV,  3'd1, 3'd0, 1'b0, 8'hFF); wb8("b.movff",   3'd1, 8'hFF, 5'h19);
        issue8(OP_ADD,  3'd1, 3'd0, 1'b0, 8'h01); wb8("b.addwrap", 3'd1, 8'h00, 5'h1B);
        issue8(OP_ADDC, 3'd0, 3'd0, 1'b0, 8'h00); wb8("b.addc",    3'd0, 8'h01, 5'h09);
        issue8(OP_MOV,  3'd3, 3'd0, 1'b0, 8'h7F); wb8("b.mov7f",   3'd3, 8'h7F, 5'h09);
        issue8(OP_ADD,  3'd3, 3'd0, 1'b0, 8'h01); wb8("b.addovf",  3'd3, 8'h80, 5'h0D);
        issue8(OP_LSH,  3'd0, 3'd0, 1'b0, 8'h07); shift_wait8("b.lsh7", 7);
        wb8("b.lsh7", 3'd0, 8'h80, 5'h0D);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
